mdu_sequencer: RTL

- Multi-cycle controller for MULT/MULTU/DIV/DIVU in the EX stage.
- Accepts an operation from the decoded instruction and sequences an internal iterative multiplier or radix-2 restoring divider.
- Holds the pipeline with a stall while busy, then presents a 64-bit {hi,lo} result for one cycle so the HI/LO register file can take it (hilowrite = 2'b11 path).

---
 rtl/mdu_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: EX-stage sequencer for MULT/MULTU/DIV/DIVU.
// Drives a MUL_LAT-stage multiplier pipe or a radix-2 restoring divider,
// stalls the front of the pipe while busy, then presents {hi,lo} for one
// cycle in DONE.
// Optional build macro: MDU_DIV_ZERO_FAST_EN (divide-by-zero goes straight
// to DONE from IDLE).
module mdu_sequencer #(
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic        signed_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic        accept_mul, accept_div;
`ifdef MDU_DIV_ZERO_FAST_EN
    logic        div_zero_fast;
`endif
    logic [5:0]  cnt;
    logic        signed_q, sign_q, sign_r;
    logic [31:0] dvsr_q;
    logic [63:0] rem_q, rem_shl, rem_step;
    logic [63:0] mul_pipe [MUL_LAT];
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [31:0] abs_a, abs_b, fix_q, fix_r, div_lo;

    // Operand conditioning: magnitudes for the divider, sign-extended
    // operands for the multiplier (low 64 bits of the product are exact).
    always_comb begin
        abs_a    = (signed_op && opa[31]) ? -opa : opa;
        abs_b    = (signed_op && opb[31]) ? -opb : opb;
        mul_a    = {{32{signed_op & opa[31]}}, opa};
        mul_b    = {{32{signed_op & opb[31]}}, opb};
        mul_prod = mul_a * mul_b;
    end

    // One restoring step plus the exit sign fix-up of quotient/remainder.
    always_comb begin
        rem_shl  = {rem_q[62:0], 1'b0};
        rem_step = rem_shl;
        if (rem_shl[63:32] >= dvsr_q) begin
            rem_step = {rem_shl[63:32] - dvsr_q, rem_shl[31:1], 1'b1};
        end
        fix_q  = (signed_q && sign_q) ? -rem_q[31:0]  : rem_q[31:0];
        fix_r  = (signed_q && sign_r) ? -rem_q[63:32] : rem_q[63:32];
        div_lo = (dvsr_q == '0) ? '1 : fix_q;
    end

    // Next-state, accept strobes and stall.
    always_comb begin
        state_nx   = state;
        accept_mul = 1'b0;
        accept_div = 1'b0;
`ifdef MDU_DIV_ZERO_FAST_EN
        div_zero_fast = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (resetn && !flush) begin
                    if (start_div) begin
                        accept_div = 1'b1;
                        state_nx   = DIV;
`ifdef MDU_DIV_ZERO_FAST_EN
                        if (opb == '0) begin
                            div_zero_fast = 1'b1;
                            state_nx      = DONE;
                        end
`endif
                    end else if (start_mul) begin
                        accept_mul = 1'b1;
                        state_nx   = MUL;
                    end
                end
            end
            MUL: begin
                if (flush)                          state_nx = IDLE;
                else if (cnt == 6'(MUL_LAT - 1))    state_nx = DONE;
            end
            DIV: begin
                if (flush)                          state_nx = IDLE;
                else if (cnt == 6'(DIV_ITERS))      state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        stall_o      = accept_mul | accept_div | (state == MUL) | (state == DIV);
        busy         = (state != IDLE);
        result_valid = (state == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Operand latches, iteration counter, multiplier pipe and result hold.
    // The DIV state runs DIV_ITERS steps, then one more cycle (cnt ==
    // DIV_ITERS) that applies the sign fix-up into the result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            signed_q  <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            result_hi <= '0;
            result_lo <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
            if (accept_mul) begin
                cnt         <= '0;
                mul_pipe[0] <= mul_prod;
            end
            if (accept_div) begin
                cnt      <= '0;
                signed_q <= signed_op;
                sign_q   <= opa[31] ^ opb[31];
                sign_r   <= opa[31];
                dvsr_q   <= abs_b;
                rem_q    <= {32'h0, abs_a};
`ifdef MDU_DIV_ZERO_FAST_EN
                if (div_zero_fast) begin
                    result_hi <= opa;
                    result_lo <= '1;
                end
`endif
            end
            if (state == MUL) begin
                cnt <= cnt + 6'd1;
                if (!flush && cnt == 6'(MUL_LAT - 1)) begin
                    result_hi <= mul_pipe[MUL_LAT-1][63:32];
                    result_lo <= mul_pipe[MUL_LAT-1][31:0];
                end
            end
            if (state == DIV) begin
                if (cnt != 6'(DIV_ITERS)) begin
                    rem_q <= rem_step;
                    cnt   <= cnt + 6'd1;
                end else if (!flush) begin
                    result_hi <= fix_r;
                    result_lo <= div_lo;
                end
            end
        end
    end

endmodule
